// File: rtl/tvout_sync_gen_if.sv
// Timing bus of the TV-out sync generator.
//   interlace  : field-alternation request, sampled by the generator at frame wrap
//   cntHS/cntVS: horizontal tick and line counters
//   pixel_ce   : one-cycle pixel-tick enable
//   line_stb/frame_stb : one-cycle wrap strobes
//   field, vbl, de, out_sync : field index, blanking, active window, composite sync (active-low)
// master = the generator, slave = the consumer of the timing.
interface tvout_sync_gen_if #(
  parameter int HW = 9,
  parameter int VW = 9
);
  logic          interlace;
  logic [HW-1:0] cntHS;
  logic [VW-1:0] cntVS;
  logic          pixel_ce;
  logic          line_stb;
  logic          frame_stb;
  logic          field;
  logic          vbl;
  logic          de;
  logic          out_sync;

  modport master (
    input  interlace,
    output cntHS, cntVS, pixel_ce, line_stb, frame_stb, field, vbl, de, out_sync
  );

  modport slave (
    output interlace,
    input  cntHS, cntVS, pixel_ce, line_stb, frame_stb, field, vbl, de, out_sync
  );
endinterface

// File: rtl/tvout_sync_gen.sv
// Composite-sync / blanking timing generator for a TV-out path.
//   clk_in : sole clock, all registers on its rising edge
//   rst    : asynchronous, active-high reset
//   bus    : tvout_sync_gen_if.master (interlace in; counters, strobes,
//            field, vbl, de and out_sync out)
// A clock divider produces pixel_ce every DIV cycles; all timing state
// advances only on pixel_ce. vbl/de/out_sync are registered from the
// next counter values so they line up exactly with cntHS/cntVS.
module tvout_sync_gen #(
  parameter int DIV         = 3,
  parameter int H_TOTAL     = 512,
  parameter int HSYNC_LEN   = 37,
  parameter int H_ACT_START = 96,
  parameter int H_ACT_END   = 480,
  parameter int V_TOTAL     = 311,
  parameter int V_ACT_START = 5,
  parameter int V_ACT_END   = 309,
  parameter int VS_LINES    = 2,
  parameter int EQ_LEN      = 16,
  parameter int BROAD_GAP   = 16,
  parameter int HW          = 9,
  parameter int VW          = 9
) (
  input logic               clk_in,
  input logic               rst,
  tvout_sync_gen_if.master  bus
);

  localparam logic [4:0]    DIV_LAST   = 5'(DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H2         = HW'(H_TOTAL / 2);
  localparam logic [HW-1:0] BROAD1_END = HW'(H_TOTAL / 2 - BROAD_GAP);
  localparam logic [HW-1:0] BROAD2_END = HW'(H_TOTAL - BROAD_GAP);
  localparam logic [HW-1:0] EQ1_END    = HW'(EQ_LEN);
  localparam logic [HW-1:0] EQ2_END    = HW'(H_TOTAL / 2 + EQ_LEN);
  localparam logic [HW-1:0] HS_END     = HW'(HSYNC_LEN);
  localparam logic [HW-1:0] HA_START   = HW'(H_ACT_START);
  localparam logic [HW-1:0] HA_END     = HW'(H_ACT_END);
  localparam logic [VW-1:0] V_LAST_P   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST_I   = VW'(V_TOTAL);
  localparam logic [VW-1:0] VA_START   = VW'(V_ACT_START);
  localparam logic [VW-1:0] VA_END     = VW'(V_ACT_END);
  localparam logic [VW-1:0] VS_N       = VW'(VS_LINES);

  typedef enum logic [1:0] {
    LN_ACTIVE,    // normal line sync
    LN_BROAD,     // two broad pulses
    LN_BROAD_EQ,  // broad pulse then equalising pulse
    LN_EQ         // two equalising pulses
  } line_kind_t;

  logic [4:0]    div_cnt;
  logic          pixel_ce;
  logic [HW-1:0] cnt_hs;
  logic [VW-1:0] cnt_vs;
  logic          field_q;
  logic          interlace_q;
  logic          vbl_q;
  logic          de_q;
  logic          sync_q;

  logic [VW-1:0] last_line;
  logic          h_wrap;
  logic          v_wrap;
  logic [HW-1:0] hs_next;
  logic [VW-1:0] vs_next;
  line_kind_t    kind;
  logic          vbl_next;
  logic          de_next;
  logic          sync_low;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      pixel_ce <= 1'b0;
    end else begin
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      pixel_ce <= (div_cnt == DIV_LAST);
    end
  end

  always_comb begin
    last_line = (interlace_q && field_q) ? V_LAST_I : V_LAST_P;
    h_wrap    = (cnt_hs == H_LAST);
    v_wrap    = h_wrap && (cnt_vs == last_line);
    hs_next   = h_wrap ? '0 : cnt_hs + 1'b1;
    if (v_wrap)      vs_next = '0;
    else if (h_wrap) vs_next = cnt_vs + 1'b1;
    else             vs_next = cnt_vs;
  end

  // Decode from the next counter values; registering the result makes the
  // outputs coincide with the counters they describe.
  always_comb begin
    kind     = LN_ACTIVE;
    sync_low = 1'b0;
    vbl_next = (vs_next < VA_START) || (vs_next >= VA_END);
    de_next  = !vbl_next && (hs_next >= HA_START) && (hs_next < HA_END);
    if (!vbl_next)             kind = LN_ACTIVE;
    else if (vs_next < VS_N)   kind = LN_BROAD;
    else if (vs_next == VS_N)  kind = LN_BROAD_EQ;
    else                       kind = LN_EQ;
    unique case (kind)
      LN_ACTIVE:   sync_low = (hs_next < HS_END);
      LN_BROAD:    sync_low = (hs_next < BROAD1_END) ||
                              ((hs_next >= H2) && (hs_next < BROAD2_END));
      LN_BROAD_EQ: sync_low = (hs_next < BROAD1_END) ||
                              ((hs_next >= H2) && (hs_next < EQ2_END));
      LN_EQ:       sync_low = (hs_next < EQ1_END) ||
                              ((hs_next >= H2) && (hs_next < EQ2_END));
      default:     sync_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_hs      <= '0;
      cnt_vs      <= '0;
      field_q     <= 1'b0;
      interlace_q <= 1'b0;
      vbl_q       <= 1'b1;
      de_q        <= 1'b0;
      sync_q      <= 1'b0;
    end else if (pixel_ce) begin
      cnt_hs <= hs_next;
      cnt_vs <= vs_next;
      vbl_q  <= vbl_next;
      de_q   <= de_next;
      sync_q <= ~sync_low;
      if (v_wrap) begin
        interlace_q <= bus.interlace;
        // toggle when interlacing, otherwise pin to field 0
        field_q     <= bus.interlace & ~field_q;
      end
    end
  end

  assign bus.cntHS     = cnt_hs;
  assign bus.cntVS     = cnt_vs;
  assign bus.pixel_ce  = pixel_ce;
  assign bus.line_stb  = pixel_ce & h_wrap;
  assign bus.frame_stb = pixel_ce & v_wrap;
  assign bus.field     = field_q;
  assign bus.vbl       = vbl_q;
  assign bus.de        = de_q;
  assign bus.out_sync  = sync_q;

endmodule

// File: tb/tb_tvout_sync_gen.sv
// Bench for tvout_sync_gen: one instance with default parameters checked
// against literal line shapes, one small-geometry DIV=1 instance checked
// every cycle against a frame-tick-index reference model under random
// interlace changes and asynchronous resets.
module tb_tvout_sync_gen;

  localparam int S_DIV = 1;
  localparam int S_HT  = 64;
  localparam int S_HSL = 5;
  localparam int S_HAS = 12;
  localparam int S_HAE = 60;
  localparam int S_VT  = 21;
  localparam int S_VAS = 5;
  localparam int S_VAE = 19;
  localparam int S_VSL = 2;
  localparam int S_EQ  = 2;
  localparam int S_BG  = 4;

  // reset vector: only vbl (bit 2) is high
  localparam logic [31:0] RST_VEC = 32'h0000_0004;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  tvout_sync_gen_if #(.HW(9), .VW(9)) a_if();
  tvout_sync_gen_if #(.HW(6), .VW(5)) b_if();

  tvout_sync_gen dut_a (.clk_in(clk), .rst(rst_a), .bus(a_if));

  tvout_sync_gen #(
    .DIV(S_DIV), .H_TOTAL(S_HT), .HSYNC_LEN(S_HSL), .H_ACT_START(S_HAS),
    .H_ACT_END(S_HAE), .V_TOTAL(S_VT), .V_ACT_START(S_VAS), .V_ACT_END(S_VAE),
    .VS_LINES(S_VSL), .EQ_LEN(S_EQ), .BROAD_GAP(S_BG), .HW(6), .VW(5)
  ) dut_b (.clk_in(clk), .rst(rst_b), .bus(b_if));

  logic [31:0] obs_a;
  logic [31:0] obs_b;
  assign obs_a = {7'd0, a_if.cntHS, a_if.cntVS, a_if.pixel_ce, a_if.line_stb,
                  a_if.frame_stb, a_if.field, a_if.vbl, a_if.de, a_if.out_sync};
  assign obs_b = {14'd0, b_if.cntHS, b_if.cntVS, b_if.pixel_ce, b_if.line_stb,
                  b_if.frame_stb, b_if.field, b_if.vbl, b_if.de, b_if.out_sync};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- default-parameter instance: expectations from literal line shapes
  int e_a = 0;

  function automatic logic [31:0] exp_a(input int e);
    int t, hs, vs;
    bit pce, ls, fs, vbl, de, low;
    pce = (e > 0) && (e % 3 == 0);
    t   = (e >= 1) ? (e - 1) / 3 : 0;
    hs  = t % 512;
    vs  = t / 512;
    vbl = (vs < 5) || (vs >= 309);
    if (vs <= 1)      low = (hs <= 239) || (hs >= 256 && hs <= 495);
    else if (vs == 2) low = (hs <= 239) || (hs >= 256 && hs <= 271);
    else if (vbl)     low = (hs <= 15)  || (hs >= 256 && hs <= 271);
    else              low = (hs <= 36);
    de = !vbl && hs >= 96 && hs <= 479;
    ls = pce && hs == 511;
    fs = ls && vs == 310;
    return {7'd0, 9'(hs), 9'(vs), pce, ls, fs, 1'b0, vbl, de, !low};
  endfunction

  task automatic cycle_a();
    @(posedge clk);
    if (!rst_a) e_a++;
    @(negedge clk);
    check_eq("a_outs", obs_a, exp_a(e_a));
  endtask

  // ---- small instance: model keeps a flat tick index within the frame
  int e_b = 0;
  int k_b = 0;
  int fl_b = S_VT;
  bit fld_b = 1'b0;
  bit iq_b = 1'b0;

  function automatic bit exp_sync_b(input int hs, input int vs, input bit vbl);
    int h2;
    bit low;
    h2 = S_HT / 2;
    if (!vbl)            low = hs < S_HSL;
    else if (vs < S_VSL) low = (hs < h2 - S_BG) || (hs >= h2 && hs < S_HT - S_BG);
    else if (vs == S_VSL) low = (hs < h2 - S_BG) || (hs >= h2 && hs < h2 + S_EQ);
    else                 low = (hs < S_EQ) || (hs >= h2 && hs < h2 + S_EQ);
    return !low;
  endfunction

  function automatic logic [31:0] exp_b();
    int hs, vs;
    bit pce, ls, fs, vbl, de;
    hs  = k_b % S_HT;
    vs  = k_b / S_HT;
    pce = (e_b > 0) && (e_b % S_DIV == 0);
    ls  = pce && hs == S_HT - 1;
    fs  = ls && k_b == fl_b * S_HT - 1;
    vbl = (vs < S_VAS) || (vs >= S_VAE);
    de  = !vbl && hs >= S_HAS && hs < S_HAE;
    return {14'd0, 6'(hs), 5'(vs), pce, ls, fs, fld_b, vbl, de, exp_sync_b(hs, vs, vbl)};
  endfunction

  task automatic cycle_b();
    @(posedge clk);
    if (!rst_b) begin
      e_b++;
      if (e_b >= 2 && (e_b - 1) % S_DIV == 0) begin
        k_b++;
        if (k_b == fl_b * S_HT) begin
          k_b   = 0;
          iq_b  = b_if.interlace;
          fld_b = iq_b ? !fld_b : 1'b0;
          fl_b  = (iq_b && fld_b) ? S_VT + 1 : S_VT;
        end
      end
    end
    @(negedge clk);
    check_eq("b_outs", obs_b, exp_b());
  endtask

  task automatic async_reset_b(input int hold);
    #2 rst_b = 1'b1;
    #1 check_eq("b_async_rst", obs_b, RST_VEC);
    e_b = 0; k_b = 0; fl_b = S_VT; fld_b = 1'b0; iq_b = 1'b0;
    repeat (hold) cycle_b();
    rst_b = 1'b0;
  endtask

  task automatic run_to_frame(output int lines, output bit ok);
    lines = 0;
    ok = 1'b0;
    for (int c = 0; c < (S_VT + 2) * S_HT * S_DIV + 8 && !ok; c++) begin
      cycle_b();
      if (b_if.line_stb) lines++;
      if (b_if.frame_stb) ok = 1'b1;
    end
  endtask

  int exp_len[3] = '{S_VT, S_VT + 1, S_VT};
  bit exp_fld[3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int lines;
    bit ok;
    a_if.interlace = 1'b0;
    b_if.interlace = 1'b1;

    // default instance
    repeat (2) @(negedge clk);
    check_eq("a_reset", obs_a, RST_VEC);
    rst_a = 1'b0;
    for (int c = 0; c < 6 * 512 * 3 + 40; c++) cycle_a();
    #2 rst_a = 1'b1;
    #1 check_eq("a_async_rst", obs_a, RST_VEC);
    e_a = 0;
    repeat (2) cycle_a();
    rst_a = 1'b0;
    repeat (10) cycle_a();

    // small instance: interlace held high, field 0/1/0 with 21/22/21 lines
    check_eq("b_reset", obs_b, RST_VEC);
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_to_frame(lines, ok);
      check_eq("frame_seen", 32'(ok), 32'd1);
      check_eq("frame_len", 32'(lines), 32'(exp_len[i]));
      cycle_b();
      check_eq("field_after_wrap", 32'(b_if.field), 32'(exp_fld[i]));
    end

    // interlace dropped: current odd frame keeps 22 lines, then field 0
    b_if.interlace = 1'b0;
    run_to_frame(lines, ok);
    check_eq("odd_len", 32'(lines), 32'(S_VT + 1));
    cycle_b();
    check_eq("field_forced0", 32'(b_if.field), 32'd0);

    // interlace raised mid-frame at line 10: frame length unchanged
    repeat (10 * S_HT) cycle_b();
    b_if.interlace = 1'b1;
    repeat (S_HT / 2) cycle_b();
    check_eq("field_mid", 32'(b_if.field), 32'd0);
    run_to_frame(lines, ok);
    check_eq("mid_len", 32'(lines + 10), 32'(S_VT));
    cycle_b();
    check_eq("field_mid_wrap", 32'(b_if.field), 32'd1);

    // reset mid-line, mid-field
    repeat (7 * S_HT + 23) cycle_b();
    async_reset_b(2);
    repeat (S_HT + 4) cycle_b();

    // random interlace activity and occasional asynchronous resets
    for (int c = 0; c < 6000; c++) begin
      cycle_b();
      if ($urandom_range(0, 149) == 0) b_if.interlace = ~b_if.interlace;
      if ($urandom_range(0, 1999) == 0) async_reset_b(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tvout_sync_gen.md
TVOUT_SYNC_GEN -- requirements
Module: tvout_sync_gen

Interface
REQ-001 Parameter DIV, default 3: clk_in cycles per pixel tick; legal range 1..16.
REQ-002 Parameter H_TOTAL, default 512: pixel ticks per line; must be even.
REQ-003 Parameter HSYNC_LEN, default 37: line-sync low width in ticks.
REQ-004 Parameter H_ACT_START, default 96, and H_ACT_END, default 480: active-video column window [start, end).
REQ-005 Parameter V_TOTAL, default 311: lines per progressive frame, and lines in field 0.
REQ-006 Parameter V_ACT_START, default 5, and V_ACT_END, default 309: active line window [start, end).
REQ-007 Parameter VS_LINES, default 2: count of full broad-pulse lines starting at line 0.
REQ-008 Parameter EQ_LEN, default 16: equalising pulse low width; BROAD_GAP, default 16: high gap that ends each broad pulse.
REQ-009 Parameter HW, default 9, and VW, default 9: counter widths.
REQ-010 clk_in  in  1  sole clock; every register is clocked on its rising edge.
REQ-011 rst  in  1  reset, asynchronous, active-high.
REQ-012 interlace  in  1  1 = alternate field lengths; sampled only at frame wrap.
REQ-013 cntHS  out  HW  horizontal tick counter.
REQ-014 cntVS  out  VW  line counter.
REQ-015 pixel_ce  out  1  one-clk_in-cycle pixel-tick enable.
REQ-016 line_stb, frame_stb  out  1 each  one-cycle strobes at line wrap and frame wrap.
REQ-017 field  out  1  current field, 0 or 1.
REQ-018 vbl  out  1  vertical blanking.
REQ-019 de  out  1  active-video window.
REQ-020 out_sync  out  1  composite sync, active-low.

Function
REQ-021 Divider: div_cnt counts 0..DIV-1 on every clk_in cycle and wraps; pixel_ce=1 only in the cycle after div_cnt==DIV-1; with DIV=1, pixel_ce is held at 1.
REQ-022 Single clock domain: no derived clocks; every other register advances only in cycles where pixel_ce=1.
REQ-023 cntHS: increments on each tick; wraps from H_TOTAL-1 to 0.
REQ-024 cntVS: increments on a cntHS wrap; wraps to 0 from last_line.
REQ-025 last_line: V_TOTAL-1 when interlace_q=0 or field=0; V_TOTAL when interlace_q=1 and field=1.
REQ-026 Frame wrap: interlace is latched into interlace_q; field toggles if the newly latched value is 1, otherwise field is forced to 0.
REQ-027 Strobes: line_stb is high for the single tick cycle that performs the cntHS wrap; frame_stb is high for the tick that wraps cntVS, coincident with line_stb.
REQ-028 Alignment: vbl, de and out_sync are registered and decoded from the next counter values, so they are always consistent with the current cntHS/cntVS; there is zero-tick skew.
REQ-029 vbl=1 iff cntVS<V_ACT_START or cntVS>=V_ACT_END.
REQ-030 de=1 iff vbl=0 and H_ACT_START<=cntHS<H_ACT_END.
REQ-031 Sync rules, with H2=H_TOTAL/2:
- Active lines (vbl=0): out_sync low iff cntHS<HSYNC_LEN.
- Lines cntVS<VS_LINES: low iff cntHS<H2-BROAD_GAP, or H2<=cntHS<H_TOTAL-BROAD_GAP.
- Line cntVS==VS_LINES: low iff cntHS<H2-BROAD_GAP, or H2<=cntHS<H2+EQ_LEN.
- Other blanking lines: low iff cntHS<EQ_LEN, or H2<=cntHS<H2+EQ_LEN.
REQ-032 Arithmetic: compares are unsigned at the counter width; parameters must fit in HW/VW, and V_TOTAL must be below 2^VW-1.
REQ-033 A change on interlace mid-frame has no effect until the next frame wrap.

Reset
REQ-034 While rst=1, regardless of clk_in: div_cnt=0, cntHS=0, cntVS=0, field=0, interlace_q=0, pixel_ce=0, line_stb=0, frame_stb=0, vbl=1, de=0, out_sync=0.
REQ-035 Reset asserted mid-line or mid-field returns the block to the REQ-034 state immediately.
REQ-036 After release, the first pixel_ce occurs on the DIV-th rising clk_in edge.

Verification
REQ-037 Defaults, 3 ticks after reset: pixel_ce pulses every 3rd clk_in cycle; cntHS reads 0,1,2 on successive ticks.
REQ-038 Defaults, line 100: out_sync low for ticks 0..36 and high for 37..511; de high for ticks 96..479; line_stb high at 511->0 only.
REQ-039 Defaults, lines 0..3:
- Lines 0 and 1: low on 0..239 and 256..495.
- Line 2: low on 0..239 and 256..271.
- Line 3: low on 0..15 and 256..271.
- vbl=1 on lines 0..4 and 309..310.
REQ-040 interlace=1 held: field sequence 0,1,0 with frame lengths 311, 312 and 311 lines; frame_stb coincides with the line_stb at each wrap.
REQ-041 interlace toggled 0->1 at line 150 mid-frame: the current frame stays 311 lines and field changes only at the wrap.
REQ-042 rst pulsed at cntHS=300, cntVS=200, between clk_in edges: all outputs immediately equal the REQ-034 values; the first tick after release is cntHS 0->1.
